branch_resolve_unit: RTL and testbench

- ID-stage control-flow resolver for the 32-bit RISC-V pipeline.
- Decodes branch and jump instructions and drives operands plus a 3-bit compare code into the shared combinational 32-bit comparator; consumes its 1-bit result.
- Computes the target address and hands a redirect to the IF stage over a valid/ready handshake, stalling ID and flushing IF until the redirect is accepted.

---
 rtl/branch_resolve_unit.sv | 177 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   ID-stage control-flow resolver. It decodes branch and jump instructions and
//   drives the operands and a 3-bit compare code into the shared comparator. It
//   computes the target address and offers a redirect to IF over valid/ready.
//   While a redirect is pending, ID is stalled and IF is flushed.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   id_valid          id_inst/id_pc hold a valid instruction
//   id_inst, id_pc    instruction in ID and its PC
//   rs1_data,rs2_data forwarded register operands
//   rs_hazard         operands not yet available
//   cmp_a, cmp_b      comparator operands (rs1_data, rs2_data)
//   cmp_ctrl          comparator code
//   cmp_c             comparator result (combinational, same cycle)
//   redirect_valid    registered redirect offer to IF
//   redirect_ready    IF accepts the redirect
//   redirect_pc       registered target PC
//   id_stall          hold ID/IF pipeline registers (combinational)
//   flush_if          squash the wrong-path instruction in IF
//   misalign_exc      one-cycle registered pulse for a misaligned taken target
//
// Optional build macro BRU_STATS_EN
//   Adds stat_branches and stat_taken (32-bit wrapping counters).
module branch_resolve_unit #(
  parameter int unsigned XLEN     = 32,           // only 32 is supported
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_inst,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            rs_hazard,
  output logic [XLEN-1:0] cmp_a,
  output logic [XLEN-1:0] cmp_b,
  output logic [2:0]      cmp_ctrl,
  input  logic            cmp_c,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_pc,
  output logic            id_stall,
  output logic            flush_if,
  output logic            misalign_exc
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken
`endif
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {IDLE, WAIT_OPND, REDIRECT} state_t;
  state_t state;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_br, is_jal, is_jalr, is_cf, needs_rs;
  logic [XLEN-1:0] imm_b, imm_j, imm_i, jalr_sum, target;
  logic            taken, eval, do_redirect, do_exc;

  assign opcode  = id_inst[6:0];
  assign funct3  = id_inst[14:12];
  assign is_br   = (opcode == OP_BRANCH);
  assign is_jal  = (opcode == OP_JAL);
  assign is_jalr = (opcode == OP_JALR);
  assign is_cf   = is_br | is_jal | is_jalr;
  // JAL has no register source, so it never waits on operands.
  assign needs_rs = is_br | is_jalr;

  assign cmp_a = rs1_data;
  assign cmp_b = rs2_data;

  // Reserved funct3 values 010/011 map to code 000. The comparator returns 0
  // for that code, so those branches resolve as not taken.
  always_comb begin
    cmp_ctrl = 3'b000;
    if (is_br) begin
      case (funct3)
        3'b000:  cmp_ctrl = 3'b001; // BEQ
        3'b001:  cmp_ctrl = 3'b010; // BNE
        3'b100:  cmp_ctrl = 3'b011; // BLT
        3'b101:  cmp_ctrl = 3'b101; // BGE
        3'b110:  cmp_ctrl = 3'b100; // BLTU
        3'b111:  cmp_ctrl = 3'b110; // BGEU
        default: cmp_ctrl = 3'b000;
      endcase
    end
  end

  assign imm_b = {{19{id_inst[31]}}, id_inst[31], id_inst[7], id_inst[30:25],
                  id_inst[11:8], 1'b0};
  assign imm_j = {{11{id_inst[31]}}, id_inst[31], id_inst[19:12], id_inst[20],
                  id_inst[30:21], 1'b0};
  assign imm_i = {{20{id_inst[31]}}, id_inst[31:20]};
  assign jalr_sum = rs1_data + imm_i;

  always_comb begin
    target = id_pc + imm_b;
    if (is_jal)       target = id_pc + imm_j;
    else if (is_jalr) target = {jalr_sum[XLEN-1:1], 1'b0};
  end

  assign taken = is_br ? cmp_c : (is_jal | is_jalr);

  // The same evaluation applies in IDLE and on the cycle WAIT_OPND sees the
  // hazard clear, because the held instruction is still on id_inst.
  assign eval        = id_valid && (state != REDIRECT) && !(needs_rs && rs_hazard);
  assign do_redirect = eval && is_cf && taken && (target[1:0] == 2'b00);
  assign do_exc      = eval && is_cf && taken && (target[1:0] != 2'b00);

  // The stall is released on the evaluation cycle. A not-taken branch then
  // leaves ID and is not evaluated a second time.
  always_comb begin
    case (state)
      IDLE:      id_stall = id_valid && needs_rs && rs_hazard;
      WAIT_OPND: id_stall = rs_hazard;
      REDIRECT:  id_stall = 1'b1;
      default:   id_stall = 1'b0;
    endcase
  end

  assign flush_if = (state == REDIRECT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= RESET_PC;
      misalign_exc   <= 1'b0;
    end else begin
      misalign_exc <= do_exc;
      case (state)
        IDLE, WAIT_OPND: begin
          if (do_redirect) begin
            state          <= REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= target;
          end else if (id_stall) begin
            state <= WAIT_OPND;
          end else begin
            state <= IDLE;
          end
        end
        REDIRECT: begin
          // redirect_pc keeps its value until IF takes it.
          if (redirect_ready) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches <= '0;
      stat_taken    <= '0;
    end else begin
      if (eval && is_br)        stat_branches <= stat_branches + 32'd1;
      if (do_redirect && is_br) stat_taken    <= stat_taken + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  logic        clk = 1'b0, rst_n = 1'b0, id_valid = 1'b0;
  logic [31:0] id_inst = '0, id_pc = '0, rs1_data = '0, rs2_data = '0;
  logic        rs_hazard = 1'b0, redirect_ready = 1'b0, cmp_c;
  logic [31:0] cmp_a, cmp_b, redirect_pc;
  logic [2:0]  cmp_ctrl;
  logic        redirect_valid, id_stall, flush_if, misalign_exc;
`ifdef BRU_STATS_EN
  logic [31:0] stat_branches, stat_taken;
`endif
  int n_tests = 0, n_fail = 0;

  branch_resolve_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs_hazard(rs_hazard),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_ctrl(cmp_ctrl), .cmp_c(cmp_c),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .id_stall(id_stall), .flush_if(flush_if),
    .misalign_exc(misalign_exc)
`ifdef BRU_STATS_EN
    , .stat_branches(stat_branches), .stat_taken(stat_taken)
`endif
  );

  always #5 clk = ~clk;

  // Shared external comparator
  always_comb begin
    case (cmp_ctrl)
      3'b001:  cmp_c = (cmp_a == cmp_b);
      3'b010:  cmp_c = (cmp_a != cmp_b);
      3'b011:  cmp_c = ($signed(cmp_a) < $signed(cmp_b));
      3'b101:  cmp_c = ($signed(cmp_a) >= $signed(cmp_b));
      3'b100:  cmp_c = (cmp_a < cmp_b);
      3'b110:  cmp_c = (cmp_a >= cmp_b);
      default: cmp_c = 1'b0;
    endcase
  end

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] o);
    return {o[12], o[10:5], 5'd2, 5'd1, f3, o[4:1], o[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] o);
    return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_jalr(input logic [11:0] o);
    return {o, 5'd1, 3'b000, 5'd1, 7'b1100111};
  endfunction

  // Reference: branch outcome straight from the ISA definition
  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction
  function automatic logic [2:0] ref_ctrl(input logic [2:0] f3);
    case (f3)
      3'd0: return 3'b001; 3'd1: return 3'b010; 3'd4: return 3'b011;
      3'd5: return 3'b101; 3'd6: return 3'b100; 3'd7: return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  task automatic step(input logic v, input logic [31:0] inst, pc, r1, r2,
                      input logic hz, rdy);
    @(negedge clk);
    id_valid = v; id_inst = inst; id_pc = pc; rs1_data = r1; rs2_data = r2;
    rs_hazard = hz; redirect_ready = rdy;
    #1;
  endtask

  task automatic test_reset;
    #3;
    n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", redirect_valid); end
    n_tests++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", redirect_pc); end
    n_tests++; if (misalign_exc !== 1'b0 || flush_if !== 1'b0 || id_stall !== 1'b0) begin n_fail++; $display("FAIL reset_ctl got exc=%0b flush=%0b stall=%0b want 0", misalign_exc, flush_if, id_stall); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_beq;
    step(1, enc_b(3'd0, 13'h020), 32'h100, 5, 5, 0, 1);
    n_tests++; if (cmp_ctrl !== 3'b001) begin n_fail++; $display("FAIL beq_ctrl got %b want 001", cmp_ctrl); end
    n_tests++; if (id_stall !== 1'b0 || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL beq_dec got stall=%0b valid=%0b want 0 0", id_stall, redirect_valid); end
    step(0, 0, 0, 0, 0, 0, 1);
    n_tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h120 || flush_if !== 1'b1) begin n_fail++; $display("FAIL beq_redir got valid=%0b pc=%h flush=%0b want 1 120 1", redirect_valid, redirect_pc, flush_if); end
    step(0, 0, 0, 0, 0, 0, 1);
    n_tests++; if (redirect_valid !== 1'b0 || flush_if !== 1'b0) begin n_fail++; $display("FAIL beq_idle got valid=%0b flush=%0b want 0 0", redirect_valid, flush_if); end
  endtask

  task automatic test_blt_bltu;
    step(1, enc_b(3'd4, 13'h040), 32'h300, 32'hFFFF_FFFF, 1, 0, 1);
    n_tests++; if (cmp_ctrl !== 3'b011) begin n_fail++; $display("FAIL blt_ctrl got %b want 011", cmp_ctrl); end
    step(0, 0, 0, 0, 0, 0, 1);
    n_tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h340) begin n_fail++; $display("FAIL blt_redir got valid=%0b pc=%h want 1 340", redirect_valid, redirect_pc); end
    step(1, enc_b(3'd6, 13'h040), 32'h400, 32'hFFFF_FFFF, 1, 0, 1);
    n_tests++; if (cmp_ctrl !== 3'b100 || id_stall !== 1'b0) begin n_fail++; $display("FAIL bltu_dec got ctrl=%b stall=%0b want 100 0", cmp_ctrl, id_stall); end
    step(0, 0, 0, 0, 0, 0, 1);
    n_tests++; if (redirect_valid !== 1'b0 || id_stall !== 1'b0) begin n_fail++; $display("FAIL bltu_nt got valid=%0b stall=%0b want 0 0", redirect_valid, id_stall); end
  endtask

  task automatic test_hazard;
    for (int c = 0; c < 3; c++) begin
      step(1, enc_b(3'd1, 13'h1FF8), 32'h200, 7, 9, 1, 1);
      n_tests++; if (id_stall !== 1'b1 || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL haz_stall c=%0d got stall=%0b valid=%0b want 1 0", c, id_stall, redirect_valid); end
    end
    step(1, enc_b(3'd1, 13'h1FF8), 32'h200, 7, 9, 0, 1);
    n_tests++; if (id_stall !== 1'b0 || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL haz_eval got stall=%0b valid=%0b want 0 0", id_stall, redirect_valid); end
    step(0, 0, 0, 0, 0, 0, 1);
    n_tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1F8) begin n_fail++; $display("FAIL haz_redir got valid=%0b pc=%h want 1 1f8", redirect_valid, redirect_pc); end
  endtask

  task automatic test_jal_wrap;
    step(1, enc_j(21'h20), 32'hFFFF_FFF0, 0, 0, 1, 0);
    n_tests++; if (id_stall !== 1'b0 || cmp_ctrl !== 3'b000) begin n_fail++; $display("FAIL jal_dec got stall=%0b ctrl=%b want 0 000", id_stall, cmp_ctrl); end
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 0, 0, 0, 0, c == 4);
      n_tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h10 || id_stall !== 1'b1) begin n_fail++; $display("FAIL jal_hold c=%0d got valid=%0b pc=%h stall=%0b want 1 10 1", c, redirect_valid, redirect_pc, id_stall); end
    end
    step(0, 0, 0, 0, 0, 0, 0);
    n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL jal_done got valid=%0b want 0", redirect_valid); end
  endtask

  task automatic test_jalr_misalign;
    step(1, enc_jalr(12'h0), 32'h500, 32'h203, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    n_tests++; if (misalign_exc !== 1'b1 || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL jalr_exc got exc=%0b valid=%0b want 1 0", misalign_exc, redirect_valid); end
    step(0, 0, 0, 0, 0, 0, 1);
    n_tests++; if (misalign_exc !== 1'b0) begin n_fail++; $display("FAIL jalr_pulse got exc=%0b want 0", misalign_exc); end
  endtask

  task automatic test_reset_mid_redirect;
    step(1, enc_j(21'h10), 32'h40, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    n_tests++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got valid=%0b want 1", redirect_valid); end
    #2 rst_n = 1'b0; #1;
    n_tests++; if (redirect_valid !== 1'b0 || flush_if !== 1'b0 || id_stall !== 1'b0 || redirect_pc !== 32'h0) begin n_fail++; $display("FAIL rstmid got valid=%0b flush=%0b stall=%0b pc=%h want 0 0 0 0", redirect_valid, flush_if, id_stall, redirect_pc); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_random;
    int kind, nhz, dly, cyc, exp_br, exp_tk;
    logic [2:0] f3, exp_ctrl;
    logic [12:0] ob; logic [20:0] oj; logic [11:0] oi;
    logic [31:0] inst, pc, r1, r2, tgt, junk;
    logic tk, needs, hz, done;
`ifdef BRU_STATS_EN
    logic [31:0] sb0, st0;
    sb0 = stat_branches; st0 = stat_taken;
`endif
    exp_br = 0; exp_tk = 0;
    for (int it = 0; it < 200; it++) begin
      kind = int'($urandom_range(0, 3));
      f3 = 3'($urandom()); ob = 13'($urandom()) & 13'h1FFE;
      oj = 21'($urandom()) & 21'h1FFFFE; oi = 12'($urandom());
      pc = $urandom() & 32'hFFFF_FFFC;
      r1 = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 4));
      r2 = ($urandom_range(0, 2) == 0) ? r1 : (($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 4)));
      exp_ctrl = 3'b000; tk = 1'b0; tgt = '0; needs = 1'b0;
      case (kind)
        0: begin inst = enc_b(f3, ob); exp_ctrl = ref_ctrl(f3); tk = ref_taken(f3, r1, r2);
                 tgt = pc + {{19{ob[12]}}, ob}; needs = 1'b1; end
        1: begin inst = enc_j(oj); tk = 1'b1; tgt = pc + {{11{oj[20]}}, oj}; end
        2: begin inst = enc_jalr(oi); tk = 1'b1; tgt = (r1 + {{20{oi[11]}}, oi}) & 32'hFFFF_FFFE; needs = 1'b1; end
        default: inst = {25'($urandom()), 7'b0110011};
      endcase
      nhz = int'($urandom_range(0, 2)); dly = int'($urandom_range(0, 2));
      if (kind == 0) begin exp_br++; if (tk && tgt[1:0] == 2'b00) exp_tk++; end
      cyc = 0; done = 1'b0;
      while (!done) begin
        step(1, inst, pc, r1, r2, cyc < nhz, 1'($urandom()));
        hz = needs && (cyc < nhz);
        n_tests++; if (cmp_ctrl !== exp_ctrl || id_stall !== hz || redirect_valid !== 1'b0 || flush_if !== 1'b0) begin n_fail++; $display("FAIL rnd_dec it=%0d got ctrl=%b stall=%0b valid=%0b flush=%0b want %b %0b 0 0", it, cmp_ctrl, id_stall, redirect_valid, flush_if, exp_ctrl, hz); end
        if (!hz) done = 1'b1;
        cyc++;
      end
      if (tk && tgt[1:0] != 2'b00) begin
        step(0, 0, 0, 0, 0, 0, 0);
        n_tests++; if (misalign_exc !== 1'b1 || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_exc it=%0d got exc=%0b valid=%0b want 1 0", it, misalign_exc, redirect_valid); end
      end else if (tk) begin
        for (int k = 0; k <= dly; k++) begin
          junk = enc_b(3'($urandom()), 13'($urandom()) & 13'h1FFE);
          step(1, junk, $urandom(), $urandom(), $urandom(), 1'($urandom()), k == dly);
          n_tests++; if (redirect_valid !== 1'b1 || redirect_pc !== tgt || id_stall !== 1'b1 || flush_if !== 1'b1 || misalign_exc !== 1'b0) begin n_fail++; $display("FAIL rnd_redir it=%0d k=%0d got valid=%0b pc=%h stall=%0b flush=%0b exc=%0b want 1 %h 1 1 0", it, k, redirect_valid, redirect_pc, id_stall, flush_if, misalign_exc, tgt); end
        end
        step(0, 0, 0, 0, 0, 0, 0);
        n_tests++; if (redirect_valid !== 1'b0 || flush_if !== 1'b0) begin n_fail++; $display("FAIL rnd_release it=%0d got valid=%0b flush=%0b want 0 0", it, redirect_valid, flush_if); end
      end else begin
        step(0, 0, 0, 0, 0, 0, 0);
        n_tests++; if (redirect_valid !== 1'b0 || misalign_exc !== 1'b0) begin n_fail++; $display("FAIL rnd_nt it=%0d got valid=%0b exc=%0b want 0 0", it, redirect_valid, misalign_exc); end
      end
    end
`ifdef BRU_STATS_EN
    n_tests++; if (stat_branches - sb0 !== 32'(exp_br) || stat_taken - st0 !== 32'(exp_tk)) begin n_fail++; $display("FAIL stats got br=%0d tk=%0d want %0d %0d", stat_branches - sb0, stat_taken - st0, exp_br, exp_tk); end
`endif
  endtask

  initial begin
    test_reset;
    test_beq;
    test_blt_bltu;
    test_hazard;
    test_jal_wrap;
    test_jalr_misalign;
    test_reset_mid_redirect;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
